// File: rtl/umi_loc_pkg.sv
// Shared encodings for the two-requester local register bus arbiter.
package umi_loc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Adder test-target register map
  localparam logic [7:0] ADDR_A = 8'h00;
  localparam logic [7:0] ADDR_B = 8'h08;
  localparam logic [7:0] ADDR_C = 8'h10;

endpackage

// File: rtl/umi_loc_rr2.sv
// Two-way round-robin pick with an override for the current lock owner.
module umi_loc_rr2 (
  input  logic [1:0] valid,
  input  logic       rr_ptr,
  input  logic       force_en,
  input  logic       force_idx,
  output logic       sel
);

  always_comb begin
    if (force_en)           sel = force_idx;
    else if (valid[rr_ptr]) sel = rr_ptr;
    else                    sel = ~rr_ptr;
  end

endmodule

// File: rtl/umi_loc_arbiter.sv
// Shares one loc_* register bus between two requesters: round-robin,
// optional bounded lock, and 1-cycle read response routing.
module umi_loc_arbiter
  import umi_loc_pkg::*;
#(
  parameter int AW       = 64,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          r0_valid,
  input  logic          r0_write,
  input  logic          r0_lock,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wrdata,
  output logic          r0_ready,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_valid,
  input  logic          r1_write,
  input  logic          r1_lock,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wrdata,
  output logic          r1_ready,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] loc_addr,
  output logic          loc_write,
  output logic          loc_read,
  output logic [DW-1:0] loc_wrdata,
  input  logic [DW-1:0] loc_rddata,
  input  logic          loc_ready
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW:0] LOCK_LIM = (CW + 1)'(LOCK_MAX);

  state_t        state;
  logic          rr_ptr;
  logic [CW-1:0] lock_cnt;
  logic          rsp_pend;
  logic          rsp_owner;

  logic          sel, sel_valid, sel_write, sel_lock, acc, lock_more;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wrdata;
  logic [CW:0]   cnt_inc;

  umi_loc_rr2 u_rr (
    .valid     ({r1_valid, r0_valid}),
    .rr_ptr    (rr_ptr),
    .force_en  (state != IDLE),
    .force_idx (state == OWN1),
    .sel       (sel)
  );

  always_comb begin
    sel_valid  = (sel == REQ1) ? r1_valid  : r0_valid;
    sel_write  = (sel == REQ1) ? r1_write  : r0_write;
    sel_lock   = (sel == REQ1) ? r1_lock   : r0_lock;
    sel_addr   = (sel == REQ1) ? r1_addr   : r0_addr;
    sel_wrdata = (sel == REQ1) ? r1_wrdata : r0_wrdata;
  end

  assign acc        = nreset & loc_ready & sel_valid;
  assign r0_ready   = nreset & loc_ready & (sel == REQ0);
  assign r1_ready   = nreset & loc_ready & (sel == REQ1);
  assign loc_write  = acc & sel_write;
  assign loc_read   = acc & ~sel_write;
  assign loc_addr   = acc ? sel_addr   : '0;
  assign loc_wrdata = acc ? sel_wrdata : '0;

  assign r0_rvalid  = nreset & rsp_pend & (rsp_owner == REQ0);
  assign r1_rvalid  = nreset & rsp_pend & (rsp_owner == REQ1);
  assign r0_rdata   = r0_rvalid ? loc_rddata : '0;
  assign r1_rdata   = r1_rvalid ? loc_rddata : '0;

  // lock_cnt is 0 in IDLE, so one rule covers both lock entry and extension
  assign cnt_inc   = {1'b0, lock_cnt} + (CW + 1)'(1);
  assign lock_more = sel_lock & (cnt_inc < LOCK_LIM);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      lock_cnt  <= '0;
      rsp_pend  <= 1'b0;
      rsp_owner <= 1'b0;
    end else begin
      rsp_pend <= loc_read;
      if (loc_read) rsp_owner <= sel;
      if (acc) begin
        rr_ptr <= ~sel;
        if (lock_more) begin
          state    <= sel ? OWN1 : OWN0;
          lock_cnt <= cnt_inc[CW-1:0];
        end else begin
          state    <= IDLE;
          lock_cnt <= '0;
        end
      end else if (loc_ready && state != IDLE && !sel_valid && !sel_lock) begin
        state    <= IDLE;
        lock_cnt <= '0;
      end
    end
  end

endmodule
